// File: rtl/nearest_linebuf_ctrl_if.sv
// Handshake and BRAM address bundle between the line-buffer controller
// and its pixel source / read requester.
interface nearest_linebuf_ctrl_if #(
    parameter int C_ADDR_WIDTH = 11
);
    logic                    in_valid;
    logic                    in_last;
    logic                    in_ready;
    logic                    bram_wen;
    logic [C_ADDR_WIDTH-1:0] bram_waddr;
    logic                    rd_start;
    logic                    rd_advance;
    logic [C_ADDR_WIDTH-1:0] bram_raddr1;
    logic [C_ADDR_WIDTH-1:0] bram_raddr2;
    logic                    rd_valid1;
    logic                    rd_valid2;
    logic                    rd_last;
    logic                    rd_err;
    logic                    busy;

    modport master (
        output in_valid, in_last, rd_start, rd_advance,
        input  in_ready, bram_wen, bram_waddr, bram_raddr1, bram_raddr2,
               rd_valid1, rd_valid2, rd_last, rd_err, busy
    );

    modport slave (
        input  in_valid, in_last, rd_start, rd_advance,
        output in_ready, bram_wen, bram_waddr, bram_raddr1, bram_raddr2,
               rd_valid1, rd_valid2, rd_last, rd_err, busy
    );
endinterface

// File: rtl/nearest_linebuf_ctrl.sv
// Ping-pong line buffer controller: writes input lines into two BRAM banks and
// reads them back with nearest-neighbour horizontal scaling, two pixels per clock.
module nearest_linebuf_ctrl #(
    parameter int C_ADDR_WIDTH = 11,
    parameter int C_FRAC_WIDTH = 16,
    parameter int C_OW_WIDTH   = 12
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [C_ADDR_WIDTH-2:0]              cfg_in_width,
    input  logic [C_OW_WIDTH-1:0]                cfg_out_width,
    input  logic [C_ADDR_WIDTH-2+C_FRAC_WIDTH:0] cfg_x_step,
    nearest_linebuf_ctrl_if.slave                bus
);
    localparam int PW = C_ADDR_WIDTH - 1;
    localparam int SW = PW + C_FRAC_WIDTH;
    localparam int AW = C_OW_WIDTH + SW;
    localparam int IW = AW - C_FRAC_WIDTH;
    localparam int CW = C_OW_WIDTH + 1;

    typedef enum logic {IDLE, RUN} state_t;

    // write side
    logic          wbank;
    logic [PW-1:0] wptr;
    logic [PW-1:0] line_w;
    logic [PW-1:0] eff_w;
    logic [1:0]    filled;
    logic [1:0]    filled_n;
    logic          wr_acc;
    logic          wr_close;

    // read side
    state_t        state, state_n;
    logic          rbank;
    logic          has_line;
    logic          nb;
    logic          accept;
    logic          reject;
    logic          run_last;
    logic [AW-1:0] acc;
    logic [AW-1:0] acc2;
    logic [CW-1:0] oc;
    logic [C_OW_WIDTH-1:0] ow_r;
    logic [SW-1:0] step_r;
    logic [PW-1:0] inw_r;
    logic [IW-1:0] int1, int2, maxi;
    logic [PW-1:0] a1, a2;
    logic          v1_r, v2_r, last_r, err_r;

    assign bus.in_ready   = !filled[wbank];
    assign wr_acc         = bus.in_valid & bus.in_ready;
    assign bus.bram_wen   = wr_acc;
    assign bus.bram_waddr = {wbank, wptr};

    // line width is taken from cfg on the first pixel and held for the rest of the line
    assign eff_w    = (wptr == '0) ? cfg_in_width : line_w;
    assign wr_close = wr_acc && (bus.in_last || (wptr == eff_w - PW'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbank  <= 1'b0;
            wptr   <= '0;
            line_w <= '0;
        end else if (wr_acc) begin
            if (wptr == '0)
                line_w <= cfg_in_width;
            if (wr_close) begin
                wbank <= ~wbank;
                wptr  <= '0;
            end else begin
                wptr <= wptr + PW'(1);
            end
        end
    end

    // reader only clears the bank it holds, writer only sets a bank that is empty
    always_comb begin
        filled_n = filled;
        if (accept && bus.rd_advance && has_line)
            filled_n[rbank] = 1'b0;
        if (wr_close)
            filled_n[wbank] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            filled <= '0;
        else
            filled <= filled_n;
    end

    assign nb       = has_line ? ~rbank : rbank;
    assign run_last = (oc + CW'(2)) >= {1'b0, ow_r};

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        reject  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.rd_start) begin
                    if (bus.rd_advance ? filled[nb] : has_line) begin
                        accept  = 1'b1;
                        state_n = RUN;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            RUN: begin
                if (run_last)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // nearest source pixel: integer part of the accumulator, clamped to the last input pixel
    always_comb begin
        acc2 = acc + AW'(step_r);
        int1 = acc[AW-1:C_FRAC_WIDTH];
        int2 = acc2[AW-1:C_FRAC_WIDTH];
        maxi = IW'(inw_r - PW'(1));
        a1   = (int1 > maxi) ? maxi[PW-1:0] : int1[PW-1:0];
        a2   = (int2 > maxi) ? maxi[PW-1:0] : int2[PW-1:0];
    end

    assign bus.bram_raddr1 = (state == RUN) ? {rbank, a1} : '0;
    assign bus.bram_raddr2 = (state == RUN) ? {rbank, a2} : '0;
    assign bus.busy        = (state == RUN);
    assign bus.rd_valid1   = v1_r;
    assign bus.rd_valid2   = v2_r;
    assign bus.rd_last     = last_r;
    assign bus.rd_err      = err_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rbank    <= 1'b0;
            has_line <= 1'b0;
            acc      <= '0;
            oc       <= '0;
            ow_r     <= '0;
            step_r   <= '0;
            inw_r    <= '0;
            v1_r     <= 1'b0;
            v2_r     <= 1'b0;
            last_r   <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            err_r  <= reject;
            v1_r   <= 1'b0;
            v2_r   <= 1'b0;
            last_r <= 1'b0;
            if (accept) begin
                if (bus.rd_advance)
                    rbank <= nb;
                has_line <= 1'b1;
                acc      <= '0;
                oc       <= '0;
                ow_r     <= cfg_out_width;
                step_r   <= cfg_x_step;
                inw_r    <= cfg_in_width;
            end else if (state == RUN) begin
                acc    <= acc + AW'({step_r, 1'b0});
                oc     <= oc + CW'(2);
                v1_r   <= oc < {1'b0, ow_r};
                v2_r   <= (oc + CW'(1)) < {1'b0, ow_r};
                last_r <= run_last;
            end
        end
    end
endmodule
